lfsr_period_monitor: RTL

Downstream checker for the 4-bit LFSR stage. It samples the LFSR `STATE` bus on the board clock and detects each state advance. It measures the sequence period as the number of advances until the first recorded state recurs, and flags lockup (all-zero state), stalls and non-returning sequences. It drives the result LEDs and lab status, and it makes no assumption about the LFSR's divided clock rate.

---
 rtl/lfsr_period_monitor.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/lfsr_period_monitor.sv
// ---------------------------------------------------------------------------
// lfsr_period_monitor
//
// Watches the STATE bus of an upstream W-bit LFSR and measures its sequence
// period: the number of state advances until the first recorded state comes
// back. It also flags an all-zero lockup, a stalled sequence and a sequence
// that never returns within 2^W advances.
//
// Ports
//   clk     in   board clock, the only clock
//   RST     in   asynchronous active-low reset
//   START   in   single-cycle request to begin a measurement
//   STATE   in   W-bit LFSR state, synchronous to clk
//   BUSY    out  measurement in progress (ARM or RUN)
//   DONE    out  result available, held until the next accepted START
//   PERIOD  out  W+1-bit advance count
//   MAXIMAL out  clean finish with PERIOD == 2^W - 1
//   LOCKUP  out  all-zero state observed
//   STALL   out  no state change for STALL_CYC - 1 cycles
//   OVF     out  2^W advances without returning to the reference state
// ---------------------------------------------------------------------------
module lfsr_period_monitor #(
    parameter int W         = 4,
    parameter int STALL_CYC = 200_000_000
) (
    input  logic         clk,
    input  logic         RST,
    input  logic         START,
    input  logic [W-1:0] STATE,
    output logic         BUSY,
    output logic         DONE,
    output logic [W:0]   PERIOD,
    output logic         MAXIMAL,
    output logic         LOCKUP,
    output logic         STALL,
    output logic         OVF
);

    localparam int SCW = (STALL_CYC > 2) ? $clog2(STALL_CYC) : 1;

    // Stall is declared on the cycle the idle count would reach STALL_CYC - 1.
    localparam logic [SCW-1:0] STALL_LIM_C = SCW'(STALL_CYC - 32'sd2);
    localparam logic [SCW-1:0] STALL_ONE_C = SCW'(32'd1);
    localparam logic [W:0]     CNT_ONE_C   = (W+1)'(32'd1);
    localparam logic [W:0]     CNT_FULL_C  = (W+1)'(32'd1 << W);
    localparam logic [W:0]     CNT_MAX_C   = CNT_FULL_C - CNT_ONE_C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e         state_r;
    state_e         state_nx_s;
    logic [W-1:0]   s_q_r;
    logic [W-1:0]   s_p_r;
    logic           chg_s;
    logic           zero_s;
    logic [W-1:0]   ref_r;
    logic [W-1:0]   ref_nx_s;
    logic [W:0]     cnt_r;
    logic [W:0]     cnt_nx_s;
    logic [W:0]     cnt_inc_s;
    logic [SCW-1:0] stall_cnt_r;
    logic [SCW-1:0] stall_cnt_nx_s;
    logic [W:0]     period_nx_s;
    logic           maximal_nx_s;
    logic           lockup_nx_s;
    logic           stall_nx_s;
    logic           ovf_nx_s;
    logic           busy_nx_s;
    logic           done_nx_s;

    assign chg_s     = (s_q_r != s_p_r);
    assign zero_s    = (s_q_r == {W{1'b0}});
    assign cnt_inc_s = cnt_r + CNT_ONE_C;

    // Two-stage sample of STATE; a difference between the stages marks an advance.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            s_q_r <= {W{1'b0}};
            s_p_r <= {W{1'b0}};
        end else begin
            s_q_r <= STATE;
            s_p_r <= s_q_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and next-result logic; event priority is lockup, return, overflow, stall.
    always_comb begin
        state_nx_s     = state_r;
        ref_nx_s       = ref_r;
        cnt_nx_s       = cnt_r;
        stall_cnt_nx_s = stall_cnt_r;
        period_nx_s    = PERIOD;
        maximal_nx_s   = MAXIMAL;
        lockup_nx_s    = LOCKUP;
        stall_nx_s     = STALL;
        ovf_nx_s       = OVF;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_nx_s     = ST_ARM;
                    cnt_nx_s       = {(W+1){1'b0}};
                    stall_cnt_nx_s = {SCW{1'b0}};
                    period_nx_s    = {(W+1){1'b0}};
                    maximal_nx_s   = 1'b0;
                    lockup_nx_s    = 1'b0;
                    stall_nx_s     = 1'b0;
                    ovf_nx_s       = 1'b0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_ARM: begin
                if (zero_s) begin
                    lockup_nx_s = 1'b1;
                    period_nx_s = cnt_r;
                    state_nx_s  = ST_DONE;
                end else if (chg_s) begin
                    // Reference is taken at a state boundary, never mid-state.
                    ref_nx_s       = s_q_r;
                    cnt_nx_s       = {(W+1){1'b0}};
                    stall_cnt_nx_s = {SCW{1'b0}};
                    state_nx_s     = ST_RUN;
                end else if (stall_cnt_r == STALL_LIM_C) begin
                    stall_nx_s  = 1'b1;
                    period_nx_s = cnt_r;
                    state_nx_s  = ST_DONE;
                end else begin
                    stall_cnt_nx_s = stall_cnt_r + STALL_ONE_C;
                end
            end
            ST_RUN: begin
                if (zero_s) begin
                    lockup_nx_s = 1'b1;
                    period_nx_s = cnt_r;
                    state_nx_s  = ST_DONE;
                end else if (chg_s) begin
                    stall_cnt_nx_s = {SCW{1'b0}};
                    cnt_nx_s       = cnt_inc_s;
                    if (s_q_r == ref_r) begin
                        // A return on the 2^W-th advance is still a clean finish.
                        period_nx_s  = cnt_inc_s;
                        maximal_nx_s = (cnt_inc_s == CNT_MAX_C);
                        state_nx_s   = ST_DONE;
                    end else if (cnt_inc_s == CNT_FULL_C) begin
                        ovf_nx_s    = 1'b1;
                        period_nx_s = CNT_FULL_C;
                        state_nx_s  = ST_DONE;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else if (stall_cnt_r == STALL_LIM_C) begin
                    stall_nx_s  = 1'b1;
                    period_nx_s = cnt_r;
                    state_nx_s  = ST_DONE;
                end else begin
                    stall_cnt_nx_s = stall_cnt_r + STALL_ONE_C;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        if ((state_nx_s == ST_ARM) || (state_nx_s == ST_RUN)) begin
            busy_nx_s = 1'b1;
        end else begin
            busy_nx_s = 1'b0;
        end

        if (state_nx_s == ST_DONE) begin
            done_nx_s = 1'b1;
        end else begin
            done_nx_s = 1'b0;
        end
    end

    // Measurement datapath and registered result outputs.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            ref_r       <= {W{1'b0}};
            cnt_r       <= {(W+1){1'b0}};
            stall_cnt_r <= {SCW{1'b0}};
            PERIOD      <= {(W+1){1'b0}};
            MAXIMAL     <= 1'b0;
            LOCKUP      <= 1'b0;
            STALL       <= 1'b0;
            OVF         <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            ref_r       <= ref_nx_s;
            cnt_r       <= cnt_nx_s;
            stall_cnt_r <= stall_cnt_nx_s;
            PERIOD      <= period_nx_s;
            MAXIMAL     <= maximal_nx_s;
            LOCKUP      <= lockup_nx_s;
            STALL       <= stall_nx_s;
            OVF         <= ovf_nx_s;
            BUSY        <= busy_nx_s;
            DONE        <= done_nx_s;
        end
    end

endmodule
